// File: rtl/lcd_cmd_sequencer_pkg.sv
// rtl/lcd_cmd_sequencer_pkg.sv - HD44780 opcodes, init ROM and sequencer state encoding
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DDRAM_L1 = 8'h80;
  localparam logic [7:0] CMD_DDRAM_L2 = 8'hC0;

  localparam int INIT_LEN = 5;

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_EN_HI = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  function automatic logic [7:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_FUNC_SET;
      3'd1:    return CMD_DISP_ON;
      3'd2:    return CMD_CLEAR;
      3'd3:    return CMD_ENTRY;
      default: return CMD_DDRAM_L1;
    endcase
  endfunction

  // Clear and home need the long settle; anything with RS=1 is data and never does.
  function automatic logic is_long_cmd(input lcd_word_t w);
    return !w.rs && (w.data == CMD_CLEAR || w.data == CMD_HOME || w.data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// rtl/lcd_cmd_sequencer_if.sv - write-FIFO side and LCD pin side of the sequencer
interface lcd_cmd_sequencer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [8:0]    iWR_DATA;
  logic          iWR_EN;
  logic          oFULL;
  logic          oOVF;
  logic [LW-1:0] oLEVEL;
  logic          oINIT_DONE;
  logic          oBUSY;
  logic [7:0]    LCD_DATA;
  logic          LCD_RS;
  logic          LCD_RW;
  logic          LCD_EN;

  modport master (
    output iWR_DATA, iWR_EN,
    input  oFULL, oOVF, oLEVEL, oINIT_DONE, oBUSY, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
  );

  modport slave (
    input  iWR_DATA, iWR_EN,
    output oFULL, oOVF, oLEVEL, oINIT_DONE, oBUSY, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
  );
endinterface

// File: rtl/lcd_cmd_sequencer_sync_fifo.sv
// rtl/lcd_cmd_sequencer_sync_fifo.sv - single-clock FIFO with level count and sticky overflow
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             accept;
  logic             take;

  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign dout   = mem[rd_ptr];
  assign take   = pop && !empty;
  // A pop at the same edge frees the slot the full-FIFO push lands in.
  assign accept = push && (!full || take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (take)   rd_ptr <= rd_ptr + 1'b1;
      case ({accept, take})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !accept) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - buffered HD44780 writer: power-up init, then drains queued RS+byte words
module lcd_cmd_sequencer #(
  parameter int CLK_DIVIDE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int INIT_DLY   = 750000,
  parameter int SHORT_DLY  = 2000,
  parameter int LONG_DLY   = 82000,
  parameter int DLY_W      = 20
) (
  input  logic              iCLK,
  input  logic              iRST,
  lcd_cmd_sequencer_if.slave bus
);
  import lcd_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DLY_W-1:0] PWRUP_LAST = DLY_W'(INIT_DLY - 1);
  localparam logic [DLY_W-1:0] EN_LAST    = DLY_W'(CLK_DIVIDE - 1);
  localparam logic [DLY_W-1:0] SHORT_LAST = DLY_W'(SHORT_DLY - 1);
  localparam logic [DLY_W-1:0] LONG_LAST  = DLY_W'(LONG_DLY - 1);

  logic [2:0]       state;
  logic [DLY_W-1:0] cnt;
  logic [2:0]       init_idx;
  logic             init_done;
  lcd_word_t        cur;
  logic             lcd_en;

  logic             pop;
  logic [8:0]       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic [LW-1:0]    fifo_level;
  logic [DLY_W-1:0] wait_last;

  assign pop       = (state == S_IDLE) && init_done && !fifo_empty;
  assign wait_last = is_long_cmd(cur) ? LONG_LAST : SHORT_LAST;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (bus.iWR_EN),
    .din   (bus.iWR_DATA),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .ovf   (fifo_ovf)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= S_PWRUP;
      cnt       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      cur       <= '0;
      lcd_en    <= 1'b0;
    end else begin
      case (state)
        S_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt      <= '0;
            cur.rs   <= 1'b0;
            cur.data <= init_word(3'd0);
            state    <= S_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (pop) begin
            cur   <= lcd_word_t'(head);
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          lcd_en <= 1'b1;
          cnt    <= '0;
          state  <= S_EN_HI;
        end
        S_EN_HI: begin
          if (cnt == EN_LAST) begin
            lcd_en <= 1'b0;
            cnt    <= '0;
            state  <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == wait_last) begin
            cnt <= '0;
            // Init words chain straight into the next setup; the queue is only served from idle.
            if (!init_done && init_idx != 3'(INIT_LEN - 1)) begin
              init_idx <= init_idx + 3'd1;
              cur.rs   <= 1'b0;
              cur.data <= init_word(init_idx + 3'd1);
              state    <= S_SETUP;
            end else begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          lcd_en <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oFULL      = fifo_full;
  assign bus.oOVF       = fifo_ovf;
  assign bus.oLEVEL     = fifo_level;
  assign bus.oINIT_DONE = init_done;
  assign bus.oBUSY      = (state != S_IDLE) || !fifo_empty;
  assign bus.LCD_DATA   = cur.data;
  assign bus.LCD_RS     = cur.rs;
  assign bus.LCD_RW     = 1'b0;
  assign bus.LCD_EN     = lcd_en;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - scoreboard bench: expected EN pulses queued by stimulus, checked by a pin monitor
module tb_lcd_cmd_sequencer;

  localparam int CD    = 3;
  localparam int INITD = 10;
  localparam int SHORT = 4;
  localparam int LONG  = 20;
  localparam int DEPTH = 4;
  // EN-low cycles between pulses: settle wait + SETUP (init chain) or + IDLE + SETUP (queued words)
  localparam int G_INIT_S = SHORT + 1;
  localparam int G_INIT_L = LONG + 1;
  localparam int G_Q_S    = SHORT + 2;
  localparam int G_Q_L    = LONG + 2;

  typedef struct {
    logic [8:0] w;
    int         gap;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  lcd_cmd_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  lcd_cmd_sequencer #(
    .CLK_DIVIDE (CD),
    .FIFO_DEPTH (DEPTH),
    .INIT_DLY   (INITD),
    .SHORT_DLY  (SHORT),
    .LONG_DLY   (LONG),
    .DLY_W      (20)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic expect_pulse(input logic [8:0] w, input int gap);
    exp_t e;
    e.w = w;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic expect_init();
    expect_pulse(9'h038, INITD);
    expect_pulse(9'h00C, G_INIT_S);
    expect_pulse(9'h001, G_INIT_S);
    expect_pulse(9'h006, G_INIT_L);
    expect_pulse(9'h080, G_INIT_S);
  endtask

  // Called at posedge+1; the word is captured at the next posedge, returns 1 ns after it.
  task automatic push(input logic [8:0] w);
    bus.iWR_DATA = w;
    bus.iWR_EN   = 1'b1;
    @(posedge iCLK);
    #1;
    bus.iWR_EN   = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!bus.oINIT_DONE && n < 300) begin
      @(negedge iCLK);
      n++;
    end
    chk(name, bus.oINIT_DONE, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge iCLK);
    while (bus.oBUSY && n < 300) begin
      @(negedge iCLK);
      n++;
    end
    chk(name, bus.oBUSY, 1'b0);
  endtask

  // Pin monitor: every EN rise must match the head of the expected queue.
  logic prev_en = 1'b0;
  int   hi = 0;
  int   lo = 0;
  exp_t e_mon;

  always @(negedge iCLK) begin
    if (iRST) begin
      prev_en = 1'b0;
      hi = 0;
      lo = 0;
    end else begin
      if (bus.LCD_EN) begin
        if (!prev_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse got=%0h want=none t=%0t", {bus.LCD_RS, bus.LCD_DATA}, $time);
          end else begin
            e_mon = exp_q.pop_front();
            chk("pulse_word", {23'd0, bus.LCD_RS, bus.LCD_DATA}, {23'd0, e_mon.w});
            if (e_mon.gap >= 0) chk("pulse_gap", lo, e_mon.gap);
          end
          hi = 1;
        end else begin
          hi++;
        end
      end else begin
        if (prev_en) begin
          chk("en_width", hi, CD);
          lo = 1;
        end else begin
          lo++;
        end
      end
      prev_en = bus.LCD_EN;
    end
  end

  initial begin
    int prev_lvl;
    int n;
    bus.iWR_DATA = '0;
    bus.iWR_EN   = 1'b0;

    // Reset state
    repeat (2) @(negedge iCLK);
    chk("rst_en",    bus.LCD_EN, 1'b0);
    chk("rst_data",  bus.LCD_DATA, 8'h00);
    chk("rst_rs",    bus.LCD_RS, 1'b0);
    chk("rst_rw",    bus.LCD_RW, 1'b0);
    chk("rst_init",  bus.oINIT_DONE, 1'b0);
    chk("rst_ovf",   bus.oOVF, 1'b0);
    chk("rst_level", bus.oLEVEL, 3'd0);
    chk("rst_full",  bus.oFULL, 1'b0);
    chk("rst_busy",  bus.oBUSY, 1'b1);

    // Init sequence
    expect_init();
    #1 iRST = 1'b0;
    wait_init("init_done_a");
    chk("init_pulses_a", exp_q.size(), 0);
    chk("idle_after_init", bus.oBUSY, 1'b0);

    // Single data word latency
    @(posedge iCLK); #1;
    expect_pulse(9'h141, -1);
    push(9'h141);
    @(negedge iCLK);
    chk("lvl_after_push", bus.oLEVEL, 3'd1);
    @(negedge iCLK);
    chk("pop_rs",   bus.LCD_RS, 1'b1);
    chk("pop_data", bus.LCD_DATA, 8'h41);
    chk("pop_en",   bus.LCD_EN, 1'b0);
    chk("pop_lvl",  bus.oLEVEL, 3'd0);
    repeat (7) @(negedge iCLK);
    chk("busy_in_wait", bus.oBUSY, 1'b1);
    @(negedge iCLK);
    chk("busy_low", bus.oBUSY, 1'b0);

    // Long vs short settle
    @(posedge iCLK); #1;
    expect_pulse(9'h001, -1);
    expect_pulse(9'h142, G_Q_L);
    expect_pulse(9'h101, G_Q_S);
    expect_pulse(9'h143, G_Q_S);
    push(9'h001);
    push(9'h142);
    push(9'h101);
    push(9'h143);
    wait_idle("idle_c");
    chk("pulses_c", exp_q.size(), 0);

    // Full FIFO, pop and push at the same edge
    @(posedge iCLK); #1;
    expect_pulse(9'h160, -1);
    expect_pulse(9'h161, G_Q_S);
    expect_pulse(9'h162, G_Q_S);
    expect_pulse(9'h163, G_Q_S);
    expect_pulse(9'h164, G_Q_S);
    expect_pulse(9'h165, G_Q_S);
    push(9'h160);
    push(9'h161);
    push(9'h162);
    push(9'h163);
    push(9'h164);
    repeat (5) @(posedge iCLK);
    #1;
    chk("full_before_pp", bus.oFULL, 1'b1);
    chk("lvl_before_pp", bus.oLEVEL, 3'd4);
    push(9'h165);
    chk("lvl_after_pp", bus.oLEVEL, 3'd4);
    chk("ovf_after_pp", bus.oOVF, 1'b0);
    wait_idle("idle_e");
    chk("pulses_e", exp_q.size(), 0);
    chk("ovf_end_e", bus.oOVF, 1'b0);

    // Reset during EN high, then overflow during power-up
    @(posedge iCLK); #1;
    push(9'h170);
    n = 0;
    while (!bus.LCD_EN && n < 10) begin
      @(posedge iCLK); #1;
      n++;
    end
    chk("en_before_rst", bus.LCD_EN, 1'b1);
    #1 iRST = 1'b1;
    #1;
    chk("rst_async_en",   bus.LCD_EN, 1'b0);
    chk("rst_async_lvl",  bus.oLEVEL, 3'd0);
    chk("rst_async_init", bus.oINIT_DONE, 1'b0);
    repeat (2) @(negedge iCLK);
    expect_init();
    expect_pulse(9'h150, G_Q_S);
    expect_pulse(9'h151, G_Q_S);
    expect_pulse(9'h152, G_Q_S);
    expect_pulse(9'h002, G_Q_S);
    #1 iRST = 1'b0;
    @(posedge iCLK); #1;
    push(9'h150);
    push(9'h151);
    push(9'h152);
    push(9'h002);
    push(9'h1EE);
    push(9'h1EF);
    @(negedge iCLK);
    chk("pwrup_lvl",  bus.oLEVEL, 3'd4);
    chk("pwrup_full", bus.oFULL, 1'b1);
    chk("pwrup_ovf",  bus.oOVF, 1'b1);
    chk("pwrup_init", bus.oINIT_DONE, 1'b0);
    wait_init("init_done_d");
    chk("lvl_at_init_d", bus.oLEVEL, 3'd4);
    prev_lvl = 4;
    n = 0;
    while (prev_lvl > 0 && n < 300) begin
      @(negedge iCLK);
      n++;
      if (int'(bus.oLEVEL) != prev_lvl) begin
        chk("lvl_step", bus.oLEVEL, prev_lvl - 1);
        prev_lvl = prev_lvl - 1;
      end
    end
    chk("lvl_drained", bus.oLEVEL, 3'd0);
    wait_idle("idle_d");
    chk("pulses_d", exp_q.size(), 0);
    chk("ovf_sticky", bus.oOVF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
